demux1: RTL and testbench

- Two-way steering block for 32-bit data, the demultiplexing counterpart of the 2:1 datapath mux.
- Accepts one valid/ready input stream carrying a destination select bit.
- Routes each accepted word to one of two output channels, each buffered in its own small FIFO.
- Used in the processor datapath to split one result stream, e.g. ALU versus memory write-back, toward two consumers that stall independently.

---
 rtl/demux1_pkg.sv | 8 +
 rtl/demux1_fifo.sv | 89 ++++++++
 rtl/demux1.sv | 73 +++++++
 tb/tb_demux1.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/demux1_pkg.sv
// Shared constants for the two-way result-stream demultiplexer.
package demux1_pkg;

  localparam int   WORD_W = 32;
  localparam logic CH0    = 1'b0;
  localparam logic CH1    = 1'b1;

endpackage

// File: rtl/demux1_fifo.sv
// Small per-channel FIFO: storage, wrap-around pointers and occupancy count.
module demux1_fifo
  import demux1_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]  PTR_ZERO = {PW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en;
  logic             pop_en;

  // Guarded handshakes keep the FIFO consistent even if a caller misbehaves.
  always_comb begin
    push_en = push && (cnt_q != CNT_FULL);
    pop_en  = pop && (cnt_q != CNT_ZERO);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = PTR_ZERO;
      rd_d  = PTR_ZERO;
      cnt_d = CNT_ZERO;
    end else begin
      if (push_en) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop_en) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= PTR_ZERO;
      rd_q  <= PTR_ZERO;
      cnt_q <= CNT_ZERO;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is zeroed on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (!flush && push_en) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = cnt_q;

endmodule

// File: rtl/demux1.sv
// Steers one valid/ready stream into two independently stalling FIFO channels.
module demux1
  import demux1_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic room0, room1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready looks only at registered counts, never at out*_ready or in_valid.
  always_comb begin
    room0 = (cnt0 < CNT_FULL);
    room1 = (cnt1 < CNT_FULL);
    if (in_sel == CH1) begin
      in_ready = room1;
    end else begin
      in_ready = room0;
    end
    push0 = in_valid && in_ready && (in_sel == CH0);
    push1 = in_valid && in_ready && (in_sel == CH1);
    pop0  = out0_valid && out0_ready;
    pop1  = out1_valid && out1_ready;
  end

  assign out0_valid = (cnt0 != CNT_ZERO);
  assign out1_valid = (cnt1 != CNT_ZERO);

  demux1_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .head_data (out0_data),
    .count     (cnt0)
  );

  demux1_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .head_data (out1_data),
    .count     (cnt1)
  );

endmodule

// File: tb/tb_demux1.sv
// Self-checking bench for demux1: directed vector table, async reset, random streaming.
module tb_demux1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid, out1_ready;
  logic [31:0] out1_data;
  logic [1:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  demux1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        sel;
    logic [31:0] data;
    logic        r0;
    logic        r1;
    logic        fl;
    logic        rdy;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [31:0] d,
                       input logic r0, input logic r1, input logic fl);
    in_valid   = iv;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    flush      = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        hold;
    logic        exp_rdy;
    int          pushes;
    int          cycles;

    vecs[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h11,       1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 32'h0,        32'h11};
    vecs[3]  = '{1'b1, 1'b1, 32'h22,       1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h0,        32'h11};
    vecs[4]  = '{1'b1, 1'b1, 32'h33,       1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 32'h0,        32'h11};
    vecs[5]  = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 32'hA5A5A5A5, 32'h11};
    vecs[6]  = '{1'b1, 1'b1, 32'h33,       1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 32'hA5A5A5A5, 32'h22};
    vecs[7]  = '{1'b1, 1'b1, 32'h33,       1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 32'hA5A5A5A5, 32'h33};
    vecs[8]  = '{1'b1, 1'b0, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 32'h5,        32'h33};
    vecs[9]  = '{1'b1, 1'b0, 32'h77,       1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 32'h5,        32'h33};
    vecs[10] = '{1'b1, 1'b1, 32'h88,       1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 32'h5,        32'h33};
    vecs[11] = '{1'b1, 1'b0, 32'h99,       1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h66,       1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 32'h66,       32'h0};
    vecs[13] = '{1'b1, 1'b1, 32'h44,       1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 32'h66,       32'h44};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_v0",   32'(out0_valid), 32'h0);
      chk("rst_v1",   32'(out1_valid), 32'h0);
      chk("rst_d0",   out0_data,       32'h0);
      chk("rst_d1",   out1_data,       32'h0);
      chk("rst_cnt0", 32'(cnt0),       32'h0);
      chk("rst_cnt1", 32'(cnt1),       32'h0);
    end
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vecs[i].rdy));
      step();
      chk($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].c0));
      chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].c1));
      chk($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(vecs[i].c0 != 2'd0));
      chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(vecs[i].c1 != 2'd0));
      if (vecs[i].c0 != 2'd0) chk($sformatf("vec%0d_d0", i), out0_data, vecs[i].d0);
      if (vecs[i].c1 != 2'd0) chk($sformatf("vec%0d_d1", i), out1_data, vecs[i].d1);
    end

    // Refill both channels, then drop reset between clock edges.
    drive(1'b1, 1'b0, 32'h67, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h45, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("refill_cnt0", 32'(cnt0), 32'd2);
    chk("refill_cnt1", 32'(cnt1), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_v0",   32'(out0_valid), 32'h0);
    chk("arst_v1",   32'(out1_valid), 32'h0);
    chk("arst_cnt0", 32'(cnt0),       32'h0);
    chk("arst_cnt1", 32'(cnt1),       32'h0);
    chk("arst_d0",   out0_data,       32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Random streaming against a queue-based reference.
    hold   = 1'b0;
    pushes = 0;
    cycles = 0;
    while (pushes < 1000 && cycles < 20000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      flush      = 1'b0;
      @(negedge clk);
      exp_rdy = ((in_sel ? q1.size() : q0.size()) < 2);
      chk("rnd_rdy",  32'(in_ready),   32'(exp_rdy));
      chk("rnd_cnt0", 32'(cnt0),       32'(q0.size()));
      chk("rnd_cnt1", 32'(cnt1),       32'(q1.size()));
      chk("rnd_v0",   32'(out0_valid), 32'(q0.size() != 0));
      chk("rnd_v1",   32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("rnd_d0", out0_data, q0[0]);
      if (q1.size() != 0) chk("rnd_d1", out1_data, q1[0]);
      if (out0_ready && q0.size() != 0) void'(q0.pop_front());
      if (out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        pushes++;
      end
      hold = in_valid && !exp_rdy;
      step();
      cycles++;
    end
    chk("rnd_pushes_done", 32'(pushes), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
